// File: rtl/md03a_pkg.sv
// Shared constants for the MD03A AXI4-Lite PWM slave: register map indices,
// CTRL/STATUS bit positions, response codes and the byte-strobe merge helper.
package md03a_pkg;

  localparam int unsigned PWM_CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_STATUS = 2'd3
  } reg_idx_e;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_DIR_BIT    = 1;

  localparam int unsigned STATUS_CNT_LSB   = 0;
  localparam int unsigned STATUS_CNT_WIDTH = 16;
  localparam int unsigned STATUS_DIR_BIT   = 16;
  localparam int unsigned STATUS_PWM_BIT   = 17;
  localparam int unsigned STATUS_EN_BIT    = 18;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/md03a_pwm_gen.sv
// PWM generator for the MD03A: shadowed configuration reloaded on period
// boundaries, free-running counter, registered glitch-free pwm and dir pins.
module md03a_pwm_gen
  import md03a_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_enable,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             shadow_enable
);

  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_duty;
  logic             reload;

  // A zero period reloads every cycle so a fresh configuration is picked up
  // immediately instead of waiting for a wrap that never comes.
  always_comb begin
    reload = (sh_period == '0) || (count == sh_period - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      sh_period     <= '0;
      sh_duty       <= '0;
      shadow_enable <= 1'b0;
      dir           <= 1'b0;
      pwm           <= 1'b0;
    end else begin
      if (reload) begin
        count         <= '0;
        sh_period     <= cfg_period;
        sh_duty       <= cfg_duty;
        shadow_enable <= cfg_enable;
        dir           <= cfg_dir;
      end else begin
        count <= count + CNT_W'(1);
      end
      pwm <= shadow_enable && (sh_period != '0) && (count < sh_duty);
    end
  end

endmodule

// File: rtl/md03a_axil_pwm_slave.sv
// AXI4-Lite slave for the MD03A motor driver: independent AW/W acceptance,
// single outstanding write, 1-cycle reads, CTRL/PERIOD/DUTY/STATUS map.
module md03a_axil_pwm_slave
  import md03a_pkg::*;
#(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4,
  parameter int unsigned PWM_CNT_WIDTH        = PWM_CNT_WIDTH_DEFAULT
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              md03a_pwm,
  output logic                              md03a_dir
);

  logic                            clk;
  logic                            rst;

  logic [C_S00_AXI_DATA_WIDTH-1:0] ctrl_q;
  logic [PWM_CNT_WIDTH-1:0]        period_q;
  logic [PWM_CNT_WIDTH-1:0]        duty_q;

  logic                            aw_full;
  reg_idx_e                        aw_idx;
  logic                            w_full;
  logic [C_S00_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [C_S00_AXI_DATA_WIDTH/8-1:0] wstrb_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic aw_full_n, w_full_n, bvalid_n, rvalid_n;

  reg_idx_e                        ar_idx;
  logic [C_S00_AXI_DATA_WIDTH-1:0] status_word;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;

  logic [PWM_CNT_WIDTH-1:0]        pwm_count;
  logic                            pwm_sh_enable;
  logic                            unused_inputs;

  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  // prot and the byte-lane address bits carry no meaning for this map
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  assign s00_axi_bresp = AXI_RESP_OKAY;
  assign s00_axi_rresp = AXI_RESP_OKAY;

  // Ready flags are registered from the next-state of the latches so they
  // stay low through reset and never accept a second beat before B completes.
  always_comb begin
    aw_hs  = s00_axi_awvalid && s00_axi_awready;
    w_hs   = s00_axi_wvalid  && s00_axi_wready;
    b_hs   = s00_axi_bvalid  && s00_axi_bready;
    ar_hs  = s00_axi_arvalid && s00_axi_arready;
    r_hs   = s00_axi_rvalid  && s00_axi_rready;
    commit = aw_full && w_full && !s00_axi_bvalid;

    aw_full_n = aw_full;
    if (b_hs)  aw_full_n = 1'b0;
    if (aw_hs) aw_full_n = 1'b1;

    w_full_n = w_full;
    if (b_hs) w_full_n = 1'b0;
    if (w_hs) w_full_n = 1'b1;

    bvalid_n = s00_axi_bvalid;
    if (commit) bvalid_n = 1'b1;
    if (b_hs)   bvalid_n = 1'b0;

    rvalid_n = s00_axi_rvalid;
    if (ar_hs)     rvalid_n = 1'b1;
    else if (r_hs) rvalid_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full         <= 1'b0;
      aw_idx          <= REG_CTRL;
      w_full          <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      ctrl_q          <= '0;
      period_q        <= '0;
      duty_q          <= '0;
    end else begin
      aw_full         <= aw_full_n;
      w_full          <= w_full_n;
      s00_axi_bvalid  <= bvalid_n;
      s00_axi_rvalid  <= rvalid_n;
      s00_axi_awready <= !aw_full_n && !bvalid_n;
      s00_axi_wready  <= !w_full_n && !bvalid_n;
      s00_axi_arready <= !rvalid_n;

      if (aw_hs) aw_idx <= reg_idx_e'(s00_axi_awaddr[3:2]);
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (ar_hs) s00_axi_rdata <= rd_mux;

      if (commit) begin
        case (aw_idx)
          REG_CTRL:   ctrl_q   <= apply_wstrb(ctrl_q, wdata_q, wstrb_q);
          REG_PERIOD: period_q <= PWM_CNT_WIDTH'(apply_wstrb(32'(period_q), wdata_q, wstrb_q));
          REG_DUTY:   duty_q   <= PWM_CNT_WIDTH'(apply_wstrb(32'(duty_q), wdata_q, wstrb_q));
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_CNT_LSB +: STATUS_CNT_WIDTH] = STATUS_CNT_WIDTH'(pwm_count);
    status_word[STATUS_DIR_BIT] = md03a_dir;
    status_word[STATUS_PWM_BIT] = md03a_pwm;
    status_word[STATUS_EN_BIT]  = pwm_sh_enable;
  end

  always_comb begin
    ar_idx = reg_idx_e'(s00_axi_araddr[3:2]);
    case (ar_idx)
      REG_CTRL:   rd_mux = ctrl_q;
      REG_PERIOD: rd_mux = C_S00_AXI_DATA_WIDTH'(period_q);
      REG_DUTY:   rd_mux = C_S00_AXI_DATA_WIDTH'(duty_q);
      default:    rd_mux = status_word;
    endcase
  end

  md03a_pwm_gen #(
    .CNT_W (PWM_CNT_WIDTH)
  ) u_pwm_gen (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (ctrl_q[CTRL_ENABLE_BIT]),
    .cfg_dir       (ctrl_q[CTRL_DIR_BIT]),
    .cfg_period    (period_q),
    .cfg_duty      (duty_q),
    .pwm           (md03a_pwm),
    .dir           (md03a_dir),
    .count         (pwm_count),
    .shadow_enable (pwm_sh_enable)
  );

endmodule
